// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings and arbiter FSM state type.
package alu_pkg;

  localparam int unsigned W   = 32;
  localparam int unsigned OPW = 6;

  localparam logic [OPW-1:0] OP_ADDU  = 6'b000000;
  localparam logic [OPW-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;

  typedef enum logic {EMPTY, FULL} arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational pipeline ALU: add for ADDU/ADDIU/LW/SW, subtract for BEQ, zero otherwise.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned OPW = 6
) (
  input  logic [W-1:0]   in1_i,
  input  logic [W-1:0]   in2_i,
  input  logic [OPW-1:0] op_i,
  output logic [W-1:0]   res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADDU, OP_ADDIU, OP_LW, OP_SW: res_o = in1_i + in2_i;
      OP_BEQ:                          res_o = in1_i - in2_i;
      default:                         res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two valid/ready ports with a registered, tagged result.
// Optional rsp_zero output enabled by defining ALU_ARB_ZERO_FLAG_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [W-1:0]   req0_in1,
  input  logic [W-1:0]   req0_in2,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req1_in1,
  input  logic [W-1:0]   req1_in2,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_id
`ifdef ALU_ARB_ZERO_FLAG_EN
  ,
  output logic           rsp_zero
`endif
);

  arb_state_t     state_q;
  logic [W-1:0]   data_q;
  logic           id_q;
  logic           prio_q;
  logic           can_issue;
  logic           winner;
  logic [1:0]     grant;
  logic           xfer;
  logic [W-1:0]   alu_in1;
  logic [W-1:0]   alu_in2;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_res;

  // Contention resolves by prio_q; a lone requester wins outright.
  always_comb begin
    winner = (&req_valid) ? prio_q : req_valid[1];
    grant  = 2'b00;
    if (|req_valid) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end

  assign can_issue = (state_q == EMPTY) || rsp_ready;
  assign req_ready = grant & {2{can_issue & rst_n}};
  assign xfer      = |(req_valid & req_ready);

  assign alu_in1 = winner ? req1_in1 : req0_in1;
  assign alu_in2 = winner ? req1_in2 : req0_in2;
  assign alu_op  = winner ? req1_op  : req0_op;

  alu #(
    .W   (W),
    .OPW (OPW)
  ) u_alu (
    .in1_i (alu_in1),
    .in2_i (alu_in2),
    .op_i  (alu_op),
    .res_o (alu_res)
  );

`ifdef ALU_ARB_ZERO_FLAG_EN
  logic zero_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
`ifdef ALU_ARB_ZERO_FLAG_EN
      zero_q  <= 1'b1;
`endif
    end else begin
      if (xfer) begin
        data_q <= alu_res;
        id_q   <= winner;
        prio_q <= ~winner;
`ifdef ALU_ARB_ZERO_FLAG_EN
        zero_q <= (alu_res == '0);
`endif
      end
      case (state_q)
        EMPTY: if (xfer) state_q <= FULL;
        FULL:  if (!xfer && rsp_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
  assign rsp_zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed vector bench for alu_arbiter; checks rsp_zero when ALU_ARB_ZERO_FLAG_EN is defined.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [5:0]  req0_op, req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int total = 0;
  int bad   = 0;

  alu_arbiter #(
    .W   (32),
    .OPW (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_in1  (req0_in1),
    .req0_in2  (req0_in2),
    .req0_op   (req0_op),
    .req1_in1  (req1_in1),
    .req1_in2  (req1_in2),
    .req1_op   (req1_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [5:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [5:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        rr;
    logic [1:0]  exp_rdy;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_id;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] vld, input logic [5:0] op0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [5:0] op1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic rr);
    req_valid = vld;
    req0_op = op0; req0_in1 = a0; req0_in2 = b0;
    req1_op = op1; req1_in1 = a1; req1_in2 = b1;
    rsp_ready = rr;
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic id);
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({tag, ".rsp_data"}, rsp_data, d);
    chk({tag, ".rsp_id"}, {31'd0, rsp_id}, {31'd0, id});
`ifdef ALU_ARB_ZERO_FLAG_EN
    chk({tag, ".rsp_zero"}, {31'd0, rsp_zero}, {31'd0, (d == 32'd0)});
`endif
  endtask

  initial begin
    // port0 op, a, b | port1 op, a, b | rsp_ready | exp req_ready, rsp_valid, rsp_data, rsp_id
    vecs[0] = '{2'b01, 6'h00, 32'd5, 32'd7, 6'h00, 32'd0, 32'd0, 1'b1, 2'b01, 1'b1, 32'd12, 1'b0};
    vecs[1] = '{2'b10, 6'h00, 32'd0, 32'd0, 6'h04, 32'd3, 32'd5, 1'b1, 2'b10, 1'b1,
                32'hFFFF_FFFE, 1'b1};
    vecs[2] = '{2'b11, 6'h09, 32'hFFFF_FFFF, 32'd1, 6'h04, 32'd10, 32'd3, 1'b1, 2'b01, 1'b1,
                32'd0, 1'b0};
    vecs[3] = '{2'b11, 6'h09, 32'hFFFF_FFFF, 32'd1, 6'h04, 32'd10, 32'd3, 1'b1, 2'b10, 1'b1,
                32'd7, 1'b1};
    vecs[4] = '{2'b11, 6'h09, 32'hFFFF_FFFF, 32'd1, 6'h04, 32'd10, 32'd3, 1'b1, 2'b01, 1'b1,
                32'd0, 1'b0};
    vecs[5] = '{2'b11, 6'h09, 32'hFFFF_FFFF, 32'd1, 6'h04, 32'd10, 32'd3, 1'b1, 2'b10, 1'b1,
                32'd7, 1'b1};
    vecs[6] = '{2'b10, 6'h00, 32'd0, 32'd0, 6'h04, 32'd9, 32'd9, 1'b1, 2'b10, 1'b1, 32'd0, 1'b1};
    vecs[7] = '{2'b01, 6'h3F, 32'd4, 32'd4, 6'h00, 32'd0, 32'd0, 1'b1, 2'b01, 1'b1, 32'd0, 1'b0};
    vecs[8] = '{2'b00, 6'h00, 32'd0, 32'd0, 6'h00, 32'd0, 32'd0, 1'b1, 2'b00, 1'b0, 32'd0, 1'b0};

    rst_n = 1'b0;
    drive(2'b11, 6'h00, 32'd1, 32'd1, 6'h00, 32'd2, 32'd2, 1'b1);
    step();
    step();
    chk("reset.req_ready", {30'd0, req_ready}, 32'd0);
    chk_out("reset", 1'b0, 32'd0, 1'b0);
    rst_n = 1'b1;
    drive(2'b00, 6'h00, 32'd0, 32'd0, 6'h00, 32'd0, 32'd0, 1'b1);
    step();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].vld, vecs[i].op0, vecs[i].a0, vecs[i].b0,
            vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].rr);
      #1;
      chk($sformatf("vec%0d.req_ready", i), {30'd0, req_ready}, {30'd0, vecs[i].exp_rdy});
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_id);
    end

    // Backpressure: result 3 held while both ports wait, then back-to-back grant to port 1.
    drive(2'b01, 6'h00, 32'd1, 32'd2, 6'h00, 32'd0, 32'd0, 1'b0);
    #1;
    chk("bp.first.req_ready", {30'd0, req_ready}, 32'd1);
    step();
    chk_out("bp.first", 1'b1, 32'd3, 1'b0);
    drive(2'b11, 6'h00, 32'd4, 32'd4, 6'h04, 32'd10, 32'd3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp.hold%0d.req_ready", c), {30'd0, req_ready}, 32'd0);
      step();
      chk_out($sformatf("bp.hold%0d", c), 1'b1, 32'd3, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.release.req_ready", {30'd0, req_ready}, 32'd2);
    step();
    chk_out("bp.release", 1'b1, 32'd7, 1'b1);

    // Leave prio at 1 and the result held, then reset mid-operation.
    drive(2'b01, 6'h00, 32'd20, 32'd22, 6'h00, 32'd0, 32'd0, 1'b1);
    #1;
    chk("pre_rst.req_ready", {30'd0, req_ready}, 32'd1);
    step();
    chk_out("pre_rst", 1'b1, 32'd42, 1'b0);
    drive(2'b11, 6'h00, 32'd6, 32'd6, 6'h04, 32'd8, 32'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.req_ready", {30'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk("mid_rst.rr1.req_ready", {30'd0, req_ready}, 32'd0);
    step();
    chk_out("mid_rst", 1'b0, 32'd0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst.req_ready", {30'd0, req_ready}, 32'd1);
    step();
    chk_out("post_rst", 1'b1, 32'd12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
